// File: rtl/alert_scheduler.sv
// rtl/alert_scheduler.sv - shared-buzzer alert arbiter for timer, alarm and chime
//
// Purpose: one pending bit per alert source, a two-state IDLE/RING FSM
// serving the highest-priority pending source (timer > alarm > chime),
// per-source ring timeouts, a 300 s alarm snooze countdown and a sticky
// missed-alarm flag.
//
// Ports:
//   clk            system clock, all state on posedge
//   reset          synchronous, active-high
//   tick_1hz       one-cycle pulse per second
//   timer_req      one-cycle pulse, countdown reached zero
//   alarm_req      one-cycle pulse, time matched alarm setting
//   chime_req      one-cycle pulse, top of the hour
//   ack_btn        one-cycle pulse, silence the active alert
//   snooze_btn     one-cycle pulse, snooze the active alarm
//   buzzer         high while ringing
//   active_src     0=none 1=timer 2=alarm 3=chime
//   snooze_active  high while snooze countdown is non-zero
//   snooze_left    snooze seconds remaining, 0..300
//   missed_alarm   sticky: an alarm timed out unacknowledged
module alert_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       timer_req,
  input  logic       alarm_req,
  input  logic       chime_req,
  input  logic       ack_btn,
  input  logic       snooze_btn,
  output logic       buzzer,
  output logic [1:0] active_src,
  output logic       snooze_active,
  output logic [8:0] snooze_left,
  output logic       missed_alarm
);

  typedef enum logic [0:0] {IDLE = 1'b0, RING = 1'b1} state_t;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_TIMER = 2'd1;
  localparam logic [1:0] SRC_ALARM = 2'd2;
  localparam logic [1:0] SRC_CHIME = 2'd3;
  localparam logic [8:0] SNOOZE_SECS = 9'd300;

  // pending bits: [0]=timer, [1]=alarm, [2]=chime
  state_t     r_state, w_state_next;
  logic [2:0] r_pend, w_pend_next;
  logic [1:0] r_src, w_src_next;
  logic [5:0] r_cnt, w_cnt_next;
  logic [8:0] r_snooze, w_snooze_next;
  logic       r_missed, w_missed_next;

  logic       w_ring, w_ack, w_snooze, w_timeout, w_done, w_rearm;
  logic [5:0] w_last;
  logic [2:0] w_clr, w_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pend   <= 3'b000;
      r_src    <= SRC_NONE;
      r_cnt    <= 6'd0;
      r_snooze <= 9'd0;
      r_missed <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pend   <= w_pend_next;
      r_src    <= w_src_next;
      r_cnt    <= w_cnt_next;
      r_snooze <= w_snooze_next;
      r_missed <= w_missed_next;
    end
  end

  always_comb begin
    w_ring = (r_state == RING);
    // counter value at which the next tick ends the ring
    w_last = (r_src == SRC_CHIME) ? 6'd1 : 6'd59;

    // ack beats snooze; either beats a coinciding timeout tick
    w_ack     = w_ring & ack_btn;
    w_snooze  = w_ring & snooze_btn & ~ack_btn & (r_src == SRC_ALARM);
    w_timeout = w_ring & tick_1hz & (r_cnt == w_last) & ~ack_btn & ~w_snooze;
    w_done    = w_ack | w_snooze | w_timeout;

    w_clr = 3'b000;
    if (w_done) begin
      case (r_src)
        SRC_TIMER: w_clr = 3'b001;
        SRC_ALARM: w_clr = 3'b010;
        SRC_CHIME: w_clr = 3'b100;
        default:   w_clr = 3'b000;
      endcase
    end

    // snooze countdown; later assignments take precedence
    w_snooze_next = r_snooze;
    w_rearm       = 1'b0;
    if (tick_1hz && r_snooze != 9'd0) begin
      w_snooze_next = r_snooze - 9'd1;
      w_rearm       = (r_snooze == 9'd1);
    end
    if (alarm_req && r_snooze != 9'd0) begin
      w_snooze_next = 9'd0;
      w_rearm       = 1'b0;
    end
    if (w_ack && r_src == SRC_ALARM) w_snooze_next = 9'd0;
    if (w_snooze)                    w_snooze_next = SNOOZE_SECS;

    // a request only lands on a bit that was clear at this edge
    w_req       = {chime_req, alarm_req, timer_req};
    w_pend_next = (r_pend & ~w_clr) | (w_req & ~r_pend) | {1'b0, w_rearm, 1'b0};

    w_state_next = IDLE;
    w_src_next   = SRC_NONE;
    if (w_pend_next[0]) begin
      w_state_next = RING;
      w_src_next   = SRC_TIMER;
    end else if (w_pend_next[1]) begin
      w_state_next = RING;
      w_src_next   = SRC_ALARM;
    end else if (w_pend_next[2]) begin
      w_state_next = RING;
      w_src_next   = SRC_CHIME;
    end

    // restart on entry, on any served-source change, or after a termination
    w_cnt_next = 6'd0;
    if (w_state_next == RING && w_ring && !w_done && w_src_next == r_src) begin
      w_cnt_next = tick_1hz ? r_cnt + 6'd1 : r_cnt;
    end

    w_missed_next = r_missed;
    if (w_timeout && r_src == SRC_ALARM) w_missed_next = 1'b1;
    else if (!w_ring && ack_btn)         w_missed_next = 1'b0;
  end

  assign buzzer        = (r_state == RING);
  assign active_src    = r_src;
  assign snooze_active = (r_snooze != 9'd0);
  assign snooze_left   = r_snooze;
  assign missed_alarm  = r_missed;

endmodule

// File: tb/tb_alert_scheduler.sv
// tb/tb_alert_scheduler.sv - directed self-checking bench for alert_scheduler
module tb_alert_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       timer_req = 1'b0;
  logic       alarm_req = 1'b0;
  logic       chime_req = 1'b0;
  logic       ack_btn = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       buzzer;
  logic [1:0] active_src;
  logic       snooze_active;
  logic [8:0] snooze_left;
  logic       missed_alarm;

  int n_checks = 0;
  int n_fail   = 0;

  alert_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1hz      (tick_1hz),
    .timer_req     (timer_req),
    .alarm_req     (alarm_req),
    .chime_req     (chime_req),
    .ack_btn       (ack_btn),
    .snooze_btn    (snooze_btn),
    .buzzer        (buzzer),
    .active_src    (active_src),
    .snooze_active (snooze_active),
    .snooze_left   (snooze_left),
    .missed_alarm  (missed_alarm)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_src(input string tag, input logic b, input logic [1:0] s);
    check({tag, "_buzzer"}, {31'd0, buzzer}, {31'd0, b});
    check({tag, "_src"}, {30'd0, active_src}, {30'd0, s});
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_src("reset", 1'b0, 2'd0);
    check("reset_snz_act", {31'd0, snooze_active}, 32'd0);
    check("reset_snz_left", {23'd0, snooze_left}, 32'd0);
    check("reset_missed", {31'd0, missed_alarm}, 32'd0);

    // alarm rings one cycle after the pulse, times out after 60 ticks
    alarm_req = 1'b1; step(); alarm_req = 1'b0;
    check_src("alarm_start", 1'b1, 2'd2);
    ticks(59);
    check_src("alarm_59", 1'b1, 2'd2);
    ticks(1);
    check_src("alarm_timeout", 1'b0, 2'd0);
    check("alarm_missed", {31'd0, missed_alarm}, 32'd1);
    ack_btn = 1'b1; step(); ack_btn = 1'b0;
    check("missed_cleared", {31'd0, missed_alarm}, 32'd0);

    // chime preempted by timer; chime resumes with counter restarted
    chime_req = 1'b1; step(); chime_req = 1'b0;
    check_src("chime_start", 1'b1, 2'd3);
    ticks(1);
    timer_req = 1'b1; step(); timer_req = 1'b0;
    check_src("preempt_timer", 1'b1, 2'd1);
    ack_btn = 1'b1; step(); ack_btn = 1'b0;
    check_src("chime_resume", 1'b1, 2'd3);
    ticks(1);
    check_src("chime_1tick", 1'b1, 2'd3);
    ticks(1);
    check_src("chime_timeout", 1'b0, 2'd0);
    check("chime_no_missed", {31'd0, missed_alarm}, 32'd0);

    // snooze, re-ring after 300 ticks, snooze again, alarm_req cancels snooze
    alarm_req = 1'b1; step(); alarm_req = 1'b0;
    ticks(5);
    snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
    check_src("snooze", 1'b0, 2'd0);
    check("snooze_load", {23'd0, snooze_left}, 32'd300);
    check("snooze_act", {31'd0, snooze_active}, 32'd1);
    ticks(299);
    check("snooze_299", {23'd0, snooze_left}, 32'd1);
    check_src("snooze_299", 1'b0, 2'd0);
    ticks(1);
    check_src("rering", 1'b1, 2'd2);
    check("rering_snz", {23'd0, snooze_left}, 32'd0);
    check("rering_act", {31'd0, snooze_active}, 32'd0);
    snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
    check("resnooze", {23'd0, snooze_left}, 32'd300);
    ticks(10);
    check("resnooze_10", {23'd0, snooze_left}, 32'd290);
    alarm_req = 1'b1; step(); alarm_req = 1'b0;
    check_src("alarm_during_snz", 1'b1, 2'd2);
    check("alarm_clr_snz", {23'd0, snooze_left}, 32'd0);

    // ack and snooze together: ack wins
    ack_btn = 1'b1; snooze_btn = 1'b1; step(); ack_btn = 1'b0; snooze_btn = 1'b0;
    check_src("ack_snooze", 1'b0, 2'd0);
    check("ack_snooze_left", {23'd0, snooze_left}, 32'd0);
    check("ack_snooze_missed", {31'd0, missed_alarm}, 32'd0);

    // ack on the terminating tick counts as ack
    alarm_req = 1'b1; step(); alarm_req = 1'b0;
    ticks(59);
    tick_1hz = 1'b1; ack_btn = 1'b1; step(); tick_1hz = 1'b0; ack_btn = 1'b0;
    check_src("ack_on_timeout", 1'b0, 2'd0);
    check("ack_on_timeout_missed", {31'd0, missed_alarm}, 32'd0);

    // three simultaneous requests served in priority order
    timer_req = 1'b1; alarm_req = 1'b1; chime_req = 1'b1; step();
    timer_req = 1'b0; alarm_req = 1'b0; chime_req = 1'b0;
    check_src("all3_first", 1'b1, 2'd1);
    ack_btn = 1'b1; step(); ack_btn = 1'b0;
    check_src("all3_second", 1'b1, 2'd2);
    ack_btn = 1'b1; step(); ack_btn = 1'b0;
    check_src("all3_third", 1'b1, 2'd3);
    ack_btn = 1'b1; step(); ack_btn = 1'b0;
    check_src("all3_done", 1'b0, 2'd0);

    // timer timeout hands over to pending chime on the same edge
    timer_req = 1'b1; chime_req = 1'b1; step(); timer_req = 1'b0; chime_req = 1'b0;
    ticks(59);
    check_src("timer_59", 1'b1, 2'd1);
    ticks(1);
    check_src("timer_to_chime", 1'b1, 2'd3);
    ticks(1);
    check_src("chime_after_timer", 1'b1, 2'd3);
    ticks(1);
    check_src("chime_after_timer_done", 1'b0, 2'd0);

    // duplicate request does not restart the ring counter
    alarm_req = 1'b1; step(); alarm_req = 1'b0;
    ticks(30);
    alarm_req = 1'b1; step(); alarm_req = 1'b0;
    ticks(29);
    check_src("dup_59", 1'b1, 2'd2);
    ticks(1);
    check_src("dup_timeout", 1'b0, 2'd0);
    check("dup_missed", {31'd0, missed_alarm}, 32'd1);
    ack_btn = 1'b1; step(); ack_btn = 1'b0;

    // reset mid-snooze while timer rings; coinciding request ignored
    alarm_req = 1'b1; step(); alarm_req = 1'b0;
    snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
    ticks(150);
    check("pre_reset_snz", {23'd0, snooze_left}, 32'd150);
    timer_req = 1'b1; step(); timer_req = 1'b0;
    check_src("pre_reset_timer", 1'b1, 2'd1);
    reset = 1'b1; chime_req = 1'b1; step(); reset = 1'b0; chime_req = 1'b0;
    check_src("post_reset", 1'b0, 2'd0);
    check("post_reset_snz", {23'd0, snooze_left}, 32'd0);
    check("post_reset_act", {31'd0, snooze_active}, 32'd0);
    check("post_reset_missed", {31'd0, missed_alarm}, 32'd0);
    ticks(300);
    check_src("no_deferred_ring", 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alert_scheduler.md
ALERT_SCHEDULER -- requirements
Module: alert_scheduler

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high; sampled on posedge clk.
REQ-004 tick_1hz  input  1  one-cycle pulse, once per second, from the timekeeping datapath.
REQ-005 timer_req  input  1  one-cycle pulse: countdown timer reached zero.
REQ-006 alarm_req  input  1  one-cycle pulse: current time matched the alarm setting.
REQ-007 chime_req  input  1  one-cycle pulse: top of the hour (min=0, sec=0).
REQ-008 ack_btn  input  1  one-cycle pulse: user silences the active alert.
REQ-009 snooze_btn  input  1  one-cycle pulse: user snoozes the active alarm.
REQ-010 buzzer  output  1  shared buzzer drive.
REQ-011 active_src  output  2  0=none, 1=timer, 2=alarm, 3=chime.
REQ-012 snooze_active  output  1  high while snooze countdown is non-zero.
REQ-013 snooze_left  output  9  snooze seconds remaining, 0..300.
REQ-014 missed_alarm  output  1  sticky flag: an alarm timed out unacknowledged.

Function
REQ-015 SHALL keep one pending bit per source; a req pulse sets its bit at that posedge; a req for a bit already set is ignored.
REQ-016 SHALL use states IDLE and RING; buzzer=1 exactly when state=RING; active_src=0 in IDLE.
REQ-017 Priority: timer > alarm > chime; RING always serves the highest-priority pending source.
REQ-018 IDLE->RING on the same posedge a pending bit becomes/is set; buzzer high in the cycle after the req pulse (1-cycle latency).
REQ-019 Preemption: a higher-priority req during RING switches active_src at the next posedge; the preempted bit stays pending; ring counter restarts at 0.
REQ-020 Ring counter: 6 bits, cleared on entering RING or switching source, +1 per tick_1hz while in RING.
REQ-021 Timeout: timer/alarm at 60 ticks, chime at 2 ticks; on the terminating tick the active bit clears and the FSM moves to the next pending source, or IDLE if none, same posedge.
REQ-022 Alarm timeout (not ack/snooze) SHALL set missed_alarm; missed_alarm clears on ack_btn while in IDLE.
REQ-023 ack_btn in RING clears the active pending bit, resumes next pending or IDLE; if active is alarm, also clears snooze_left to 0.
REQ-024 snooze_btn with active_src=2: clears alarm bit, loads snooze_left=300, resumes next pending or IDLE; otherwise ignored.
REQ-025 ack_btn and snooze_btn in the same cycle: ack wins, snooze ignored.
REQ-026 snooze_left decrements by 1 per tick_1hz while non-zero, in any state; on the 1->0 tick it sets the alarm pending bit.
REQ-027 snooze_btn during an already-running snooze (i.e. after a re-ring) reloads 300; snooze count unlimited.
REQ-028 alarm_req while snooze_left!=0: sets alarm bit, clears snooze_left to 0.
REQ-029 Timeout tick coinciding with ack_btn: treated as ack (missed_alarm not set).
REQ-030 Req pulse coinciding with reset: ignored.

Reset
REQ-031 On reset: state=IDLE, all pending bits=0, ring counter=0, buzzer=0, active_src=0, snooze_active=0, snooze_left=0, missed_alarm=0.
REQ-032 Reset mid-RING or mid-snooze SHALL abort immediately with no deferred re-ring.

Verification
REQ-033 alarm_req at cycle 10, no buttons -> buzzer=1, active_src=2 from cycle 11; after 60 ticks buzzer=0, active_src=0, missed_alarm=1.
REQ-034 chime ringing, timer_req pulse -> next cycle active_src=1; ack_btn -> active_src=3 with counter 0; 2 ticks later active_src=0.
REQ-035 alarm ringing, snooze_btn -> buzzer=0, snooze_left=300; after 300 ticks buzzer=1, active_src=2, snooze_left=0.
REQ-036 alarm ringing, ack_btn and snooze_btn same cycle -> active_src=0, snooze_left=0, missed_alarm=0.
REQ-037 timer_req, alarm_req, chime_req same cycle -> served 1, then 2, then 3 as each is acked; buzzer stays 1 throughout.
REQ-038 reset asserted with snooze_left=150 and timer ringing -> next cycle all outputs 0; 300 further ticks produce no ring.
